// File: rtl/unsat_clause_sampler_pkg.sv
// Shared SAT-solver definitions: clause width, LFSR geometry and the
// sampler state encoding.
package unsat_clause_sampler_pkg;

    localparam int          CLAUSE_W  = 36;
    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } sampler_state_t;

    // An all-zero LFSR never leaves zero, so zero seeds are forced to 1.
    function automatic logic [15:0] lfsr_fix_seed(input logic [15:0] seed);
        return (seed == 16'h0000) ? 16'h0001 : seed;
    endfunction

endpackage

// File: rtl/unsat_clause_sampler_lfsr16.sv
// sat_lfsr16: 16-bit Galois LFSR (right shift, mask 16'hB400) with a
// synchronous load. Shared with the variable-select stage.
module sat_lfsr16
    import unsat_clause_sampler_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] value
);

    // Shift every cycle; a load replaces the shift for that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= lfsr_fix_seed(SEED);
        end else if (load) begin
            value <= lfsr_fix_seed(load_val);
        end else begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/unsat_clause_sampler.sv
// unsat_clause_sampler: drains the unsatisfied-clause FIFO tree after an
// evaluation round and keeps one clause chosen by reservoir sampling.
// Optional build macro UNSAT_SAMPLER_SEED_PORT_EN adds seed_i, loaded into
// the LFSR on every accepted start for reproducible rounds.
//
// state | meaning
// IDLE  | waiting for start_i
// DRAIN | reading the tree until DRAIN_IDLE quiet cycles are seen
// DONE  | one cycle: issue clause_valid_o or none_o
module unsat_clause_sampler
    import unsat_clause_sampler_pkg::*;
#(
    parameter int          CLAUSE_WIDTH = CLAUSE_W,
    parameter int          COUNT_WIDTH  = 10,
    parameter int          DRAIN_IDLE   = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    empty_i,
    input  logic [CLAUSE_WIDTH-1:0] clause_i,
    input  logic                    of_i,
`ifdef UNSAT_SAMPLER_SEED_PORT_EN
    input  logic [15:0]             seed_i,
`endif
    output logic                    rd_en_o,
    output logic [CLAUSE_WIDTH-1:0] clause_o,
    output logic                    clause_valid_o,
    output logic                    none_o,
    output logic [COUNT_WIDTH-1:0]  count_o,
    output logic                    of_o,
    output logic                    busy_o
);

    localparam int                     QUIET_W    = $clog2(DRAIN_IDLE + 1);
    localparam int                     PROD_W     = LFSR_W + COUNT_WIDTH;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;
    localparam logic [PROD_W-1:0]      PROD_LIMIT = PROD_W'(1) << LFSR_W;

    sampler_state_t     state;
    logic [QUIET_W-1:0] quiet;
    logic [QUIET_W-1:0] quiet_next;
    logic               rd_pend;
    logic [15:0]        lfsr;
    logic               lfsr_load;
    logic [15:0]        lfsr_load_val;
    logic [COUNT_WIDTH-1:0] k;
    logic [PROD_W-1:0]  prod;
    logic               replace;

`ifdef UNSAT_SAMPLER_SEED_PORT_EN
    assign lfsr_load     = (state == ST_IDLE) && start_i;
    assign lfsr_load_val = seed_i;
`else
    assign lfsr_load     = 1'b0;
    assign lfsr_load_val = 16'h0000;
`endif

    sat_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .value    (lfsr)
    );

    assign rd_en_o    = (state == ST_DRAIN) && !empty_i;
    assign busy_o     = (state != ST_IDLE);
    assign quiet_next = quiet + 1'b1;

    // Once the counter saturates, k stays at the saturated value.
    assign k       = (count_o == COUNT_MAX) ? count_o : count_o + 1'b1;
    assign prod    = PROD_W'(lfsr) * PROD_W'(k);
    assign replace = (prod < PROD_LIMIT);

    // Sequencing FSM with drain counting, reservoir update and result pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= ST_IDLE;
            clause_o       <= '0;
            count_o        <= '0;
            of_o           <= 1'b0;
            clause_valid_o <= 1'b0;
            none_o         <= 1'b0;
            quiet          <= '0;
            rd_pend        <= 1'b0;
        end else begin
            clause_valid_o <= 1'b0;
            none_o         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        count_o <= '0;
                        of_o    <= 1'b0;
                        quiet   <= '0;
                        rd_pend <= 1'b0;
                        state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    rd_pend <= rd_en_o;
                    if (of_i) begin
                        of_o <= 1'b1;
                    end
                    if (rd_pend) begin
                        if (replace) begin
                            clause_o <= clause_i;
                        end
                        if (count_o != COUNT_MAX) begin
                            count_o <= count_o + 1'b1;
                        end
                    end
                    // A word still in flight or a new arrival holds off DONE.
                    if (empty_i && !rd_pend) begin
                        quiet <= quiet_next;
                        if (quiet_next == QUIET_W'(DRAIN_IDLE)) begin
                            state <= ST_DONE;
                        end
                    end else begin
                        quiet <= '0;
                    end
                end
                ST_DONE: begin
                    clause_valid_o <= (count_o != '0);
                    none_o         <= (count_o == '0);
                    rd_pend        <= 1'b0;
                    state          <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unsat_clause_sampler.sv
// Bench for unsat_clause_sampler: a queue-based FIFO tree responder, an
// independent LFSR/reservoir reference, a table of drain rounds and a
// hand-written asynchronous-reset sequence.
module tb_unsat_clause_sampler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        empty_i;
    logic [35:0] clause_i;
    logic        of_i;
    logic        rd_en_o;
    logic [35:0] clause_o;
    logic        clause_valid_o;
    logic        none_o;
    logic [9:0]  count_o;
    logic        of_o;
    logic        busy_o;
`ifdef UNSAT_SAMPLER_SEED_PORT_EN
    logic [15:0] seed_i;
`endif

    always #5 clk = ~clk;

    unsat_clause_sampler dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start_i),
        .empty_i        (empty_i),
        .clause_i       (clause_i),
        .of_i           (of_i),
`ifdef UNSAT_SAMPLER_SEED_PORT_EN
        .seed_i         (seed_i),
`endif
        .rd_en_o        (rd_en_o),
        .clause_o       (clause_o),
        .clause_valid_o (clause_valid_o),
        .none_o         (none_o),
        .count_o        (count_o),
        .of_o           (of_o),
        .busy_o         (busy_o)
    );

    // Reference LFSR: Galois, right shift, mask B400, seeded ACE1.
    logic [15:0] lfsr_m;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_m <= 16'hACE1;
        end else begin
`ifdef UNSAT_SAMPLER_SEED_PORT_EN
            if (start_i)
                lfsr_m <= (seed_i == 16'h0000) ? 16'h0001 : seed_i;
            else
`endif
            lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
        end
    end

    typedef struct {
        int          n;
        logic [35:0] base;
        int          gap_after;
        int          gap_len;
        int          of_at;
        logic [15:0] seed;
        int          exp_count;
        bit          exp_none;
        bit          exp_of;
        int          exp_lat;
        bit          no_rd;
    } vec_t;

    vec_t        vecs[6];
    int          tests = 0;
    int          fails = 0;
    logic [35:0] q[$];
    logic [35:0] later[$];
    logic [35:0] exp_clause;
    int          exp_cnt;
    bit          rd_flag;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_row(input int idx, input vec_t v);
        int  popped;
        int  gap_cnt;
        int  n_valid;
        int  n_none;
        int  lat;
        bit  saw_rd;
        bit  done;
        longint kk;
        logic [35:0] w;
        q.delete();
        later.delete();
        for (int j = 0; j < v.n; j++) begin
            w = v.base + 36'(j);
            if (v.gap_after == 0 || j < v.gap_after) q.push_back(w);
            else later.push_back(w);
        end
        @(negedge clk);
        empty_i  = (q.size() == 0);
        clause_i = '0;
        of_i     = 1'b0;
`ifdef UNSAT_SAMPLER_SEED_PORT_EN
        seed_i   = v.seed;
`endif
        start_i  = 1'b1;
        rd_flag  = 1'b0;
        exp_cnt  = 0;
        popped   = 0;
        gap_cnt  = -1;
        n_valid  = 0;
        n_none   = 0;
        lat      = -1;
        saw_rd   = 1'b0;
        done     = 1'b0;
        for (int i = 1; i <= 300 && !done; i++) begin
            @(negedge clk);
            start_i = 1'b0;
            of_i    = (i == v.of_at);
            if (i == 1) check($sformatf("row%0d of_clear", idx), of_o, 0);
            if (rd_flag && q.size() > 0) begin
                w        = q.pop_front();
                clause_i = w;
                kk       = (exp_cnt < 1023) ? exp_cnt + 1 : 1023;
                if (longint'(lfsr_m) * kk < 65536) exp_clause = w;
                if (exp_cnt < 1023) exp_cnt++;
                popped++;
                if (later.size() > 0 && popped == v.gap_after) gap_cnt = 0;
            end else if (gap_cnt >= 0) begin
                gap_cnt++;
                if (gap_cnt > v.gap_len) begin
                    while (later.size() > 0) q.push_back(later.pop_front());
                    gap_cnt = -1;
                end
            end
            empty_i = (q.size() == 0);
            #1;
            rd_flag = rd_en_o;
            if (rd_en_o) saw_rd = 1'b1;
            if (clause_valid_o) n_valid++;
            if (none_o) n_none++;
            if (clause_valid_o || none_o) begin
                lat  = i - 1;
                done = 1'b1;
                check($sformatf("row%0d clause", idx), clause_o, exp_clause);
                check($sformatf("row%0d count", idx), count_o, 64'(v.exp_count));
                check($sformatf("row%0d ref_count", idx), count_o, 64'(exp_cnt));
                check($sformatf("row%0d of", idx), of_o, 64'(v.exp_of));
            end
        end
        check($sformatf("row%0d finished", idx), done, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (clause_valid_o) n_valid++;
            if (none_o) n_none++;
        end
        check($sformatf("row%0d valid_pulses", idx), n_valid, v.exp_none ? 0 : 1);
        check($sformatf("row%0d none_pulses", idx), n_none, v.exp_none ? 1 : 0);
        check($sformatf("row%0d busy_after", idx), busy_o, 0);
        check($sformatf("row%0d clause_held", idx), clause_o, exp_clause);
        if (v.exp_of) check($sformatf("row%0d of_held", idx), of_o, 1);
        if (v.exp_lat >= 0) check($sformatf("row%0d latency", idx), 64'(lat), 64'(v.exp_lat));
        if (v.no_rd) check($sformatf("row%0d no_rd", idx), saw_rd, 0);
    endtask

    initial begin
        int pulses;
        //          n  base               gapA gapL of  seed      cnt none of  lat  no_rd
        vecs[0] = '{0, 36'h0,             0,   0,   0,  16'h1234, 0,  1,   0,  5,   1};
        vecs[1] = '{1, 36'h0_0123_4567,   0,   0,   0,  16'h0001, 1,  0,   0,  -1,  0};
        vecs[2] = '{8, 36'h1,             0,   0,   0,  16'h1234, 8,  0,   0,  -1,  0};
        vecs[3] = '{5, 36'h9,             3,   3,   0,  16'h00AA, 5,  0,   0,  -1,  0};
        vecs[4] = '{4, 36'h20,            0,   0,   3,  16'hBEEF, 4,  0,   1,  -1,  0};
        vecs[5] = '{1, 36'hF_FFFF_FFFF,   0,   0,   0,  16'h0000, 1,  0,   0,  -1,  0};

        rst      = 1'b1;
        start_i  = 1'b0;
        empty_i  = 1'b1;
        clause_i = '0;
        of_i     = 1'b0;
`ifdef UNSAT_SAMPLER_SEED_PORT_EN
        seed_i   = 16'h0000;
`endif
        exp_clause = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst busy", busy_o, 0);
        check("rst count", count_o, 0);
        check("rst clause", clause_o, 0);
        check("rst valid", clause_valid_o, 0);
        check("rst none", none_o, 0);
        check("rst of", of_o, 0);
        check("rst rd_en", rd_en_o, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 6; r++) run_row(r, vecs[r]);

        // Asynchronous reset in the middle of a drain: no result pulse.
        @(negedge clk);
        empty_i  = 1'b0;
        clause_i = 36'h5_5555_5555;
        start_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("mid busy_before", busy_o, 1);
        #1;
        rst = 1'b1;
        #1;
        check("mid busy", busy_o, 0);
        check("mid count", count_o, 0);
        check("mid clause", clause_o, 0);
        check("mid rd_en", rd_en_o, 0);
        exp_clause = '0;
        pulses = 0;
        @(negedge clk);
        rst     = 1'b0;
        empty_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (clause_valid_o || none_o) pulses++;
        end
        check("mid no_pulse", pulses, 0);

        run_row(6, vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
